poly_eval_horner: RTL and testbench
===================================

// Module: poly_eval_horner
// PURPOSE
//  Parametrised polynomial evaluator: y = c[N]*x^N + ... + c[1]*x + c[0] mod 2^WIDTH.
//  Operands are entered one per go press/release on a shared data bus; evaluation uses
//  Horner's method on a single shared multiply/add ALU.
//  Sits between switch/key front-end (go, data_in) and LED/hex display of data_result.
//  Successor to fixed 2nd-order evaluator: arbitrary width and degree, busy/done status,
//  load-index output.
// PARAMETERS
//  WIDTH   8  operand, coefficient and result width in bits
//  DEGREE  3  polynomial degree N (>=1); DEGREE+1 coefficients stored
//  IDX_W   $clog2(DEGREE+2)  load-index width (derived localparam, not overridable)
// PORTS
//  clk          in   1      rising-edge clock
//  resetn       in   1      asynchronous active-low reset
//  go           in   1      active-high operand strobe (level, held for >=1 cycle)
//  data_in      in   WIDTH  operand value sampled while in a LOAD state
//  load_idx     out  IDX_W  operand slot being loaded: 0..DEGREE = c[DEGREE]..c[0], DEGREE+1 = x
//  busy         out  1      high during evaluation (MUL/ADD states)
//  done         out  1      one-cycle pulse when data_result updates
//  data_result  out  WIDTH  last evaluated result, held until next done
// BEHAVIOUR
//  Reset (async, any state): FSM->LOAD, load_idx=0, busy=0, done=0, data_result=0,
//    all coefficient regs, x and acc = 0. Reset mid-evaluation aborts; no done issued.
//  States: LOAD, LOAD_WAIT, MUL, ADD, FINISH.
//   LOAD: reg[load_idx] <= data_in every cycle. go=1 -> LOAD_WAIT.
//   LOAD_WAIT: no capture; stay while go=1. On go=0: if load_idx==DEGREE+1 -> MUL,
//     acc <= c[DEGREE], i <= DEGREE-1; else load_idx++ and -> LOAD.
//   MUL: acc <= acc * x (low WIDTH bits). -> ADD.
//   ADD: acc <= acc + c[i] (low WIDTH bits). If i==0 -> FINISH; else i--, -> MUL.
//   FINISH: data_result <= acc, done=1 this cycle, load_idx <= 0, -> LOAD.
//  Latency: 2*DEGREE+1 cycles from first cycle with go=0 in final LOAD_WAIT to done.
//  busy=1 exactly in MUL/ADD. go ignored in MUL/ADD/FINISH. go held through FINISH
//    lands in LOAD and is taken as c[DEGREE] press (documented, not an error).
//  Arithmetic: unsigned, all overflow wraps silently; product truncated to WIDTH bits.
//  Value captured is data_in on the clock edge go is first seen high (last LOAD cycle).
//  Outputs busy/done/load_idx are decoded from registered state (glitch-free, Moore).
// STRUCTURE
//  poly_pkg: state encoding localparams (S_LOAD..S_FINISH), ALU op codes (OP_ADD, OP_MUL).
//  Sub-module poly_alu #(WIDTH): combinational op ? a*b : a+b, truncated to WIDTH.
//  Top: control FSM + index counters, coefficient array reg [WIDTH-1:0] c[0:DEGREE],
//   x reg, acc reg, result reg; one poly_alu instance with operand muxes (acc, x, c[i]).
// TESTING
//  WIDTH=8,DEGREE=2: c=1,2,3, x=2 -> data_result=0x0B, done pulses once, busy high 4 cycles.
//  WIDTH=8,DEGREE=3: c=2,0,0,1, x=5 -> 2*125+1=251=0xFB; then c all 0xFF,x=0xFF -> wrap 0x00.
//  go held high 10 cycles per operand -> each operand captured once; load_idx steps 0..4.
//  Assert resetn low during ADD -> outputs 0 immediately (async), no done, next load idx 0.
//  go toggled during MUL/ADD -> ignored; result unchanged vs. clean run; 2nd run reuses FSM.
//  WIDTH=16,DEGREE=1: c=0x1234,0x0001, x=0x0010 -> 0x2341; latency exactly 3 cycles.

Source files
------------

// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : poly_pkg
//  Description : Shared constants for the Horner polynomial evaluator:
//                control-state encoding and ALU operation codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package poly_pkg;

    // Control FSM encoding
    localparam int                STATE_W     = 3;
    localparam logic [STATE_W-1:0] S_LOAD      = 3'd0;
    localparam logic [STATE_W-1:0] S_LOAD_WAIT = 3'd1;
    localparam logic [STATE_W-1:0] S_MUL       = 3'd2;
    localparam logic [STATE_W-1:0] S_ADD       = 3'd3;
    localparam logic [STATE_W-1:0] S_FINISH    = 3'd4;

    // ALU operation select
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage : poly_pkg
`default_nettype wire

// File: rtl/poly_alu.sv
`default_nettype none
// ============================================================================
//  Module      : poly_alu
//  Description : Combinational multiply/add unit shared by every Horner step.
//                Result is truncated to WIDTH bits (unsigned wrap-around).
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_alu
    import poly_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_sum;

    // Both results are sized to WIDTH so only the low bits are ever formed
    assign w_prod = a * b;
    assign w_sum  = a + b;
    assign y      = (op == OP_MUL) ? w_prod : w_sum;

endmodule : poly_alu
`default_nettype wire

// File: rtl/poly_eval_horner.sv
`default_nettype none
// ============================================================================
//  Module      : poly_eval_horner
//  Description : Polynomial evaluator y = c[N]*x^N + ... + c[0] mod 2^WIDTH.
//                Operands arrive one per go press on data_in (c[N] first,
//                x last); evaluation runs Horner's method on one shared
//                multiply/add ALU, alternating MUL and ADD cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module poly_eval_horner
    import poly_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEGREE = 3,
    localparam int IDX_W  = $clog2(DEGREE + 2)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [IDX_W-1:0] load_idx,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_result
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;

    logic [IDX_W-1:0]   r_load_idx;
    logic [IDX_W-1:0]   r_i;

    logic [WIDTH-1:0]   r_coef [0:DEGREE];
    logic [WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;

    logic               w_busy;
    logic               w_done;
    logic               w_alu_op;
    logic [WIDTH-1:0]   w_alu_b;
    logic [WIDTH-1:0]   w_alu_y;
    logic [WIDTH-1:0]   w_coef_sel;
    logic               w_last_slot;
    logic               w_i_zero;

    // Slot DEGREE+1 is x; all lower slots are coefficients, highest first
    assign w_last_slot = (r_load_idx == IDX_W'(DEGREE + 1));
    assign w_i_zero    = (r_i == '0);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and Moore decode of busy/done/ALU op
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        w_alu_op    = OP_ADD;
        case (r_state)
            S_LOAD: begin
                if (go) begin
                    w_state_nxt = S_LOAD_WAIT;
                end
            end
            S_LOAD_WAIT: begin
                if (!go) begin
                    w_state_nxt = w_last_slot ? S_MUL : S_LOAD;
                end
            end
            S_MUL: begin
                w_busy      = 1'b1;
                w_alu_op    = OP_MUL;
                w_state_nxt = S_ADD;
            end
            S_ADD: begin
                w_busy      = 1'b1;
                w_alu_op    = OP_ADD;
                w_state_nxt = w_i_zero ? S_FINISH : S_MUL;
            end
            S_FINISH: begin
                w_done      = 1'b1;
                w_state_nxt = S_LOAD;
            end
            default: begin
                w_state_nxt = S_LOAD;
            end
        endcase
    end

    // Coefficient read port addressed by the Horner step index
    always_comb begin
        w_coef_sel = '0;
        for (int k = 0; k <= DEGREE; k++) begin
            if (r_i == IDX_W'(k)) begin
                w_coef_sel = r_coef[k];
            end
        end
    end

    // Multiply always pairs acc with x; add pairs acc with the current coefficient
    assign w_alu_b = (w_alu_op == OP_MUL) ? r_x : w_coef_sel;

    poly_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op (w_alu_op),
        .a  (r_acc),
        .b  (w_alu_b),
        .y  (w_alu_y)
    );

    // Operand capture: the addressed slot tracks data_in on every LOAD cycle,
    // so the value kept is the one present on the edge where go is first seen
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x <= '0;
            for (int k = 0; k <= DEGREE; k++) begin
                r_coef[k] <= '0;
            end
        end else if (r_state == S_LOAD) begin
            if (w_last_slot) begin
                r_x <= data_in;
            end else begin
                for (int k = 0; k <= DEGREE; k++) begin
                    if (r_load_idx == IDX_W'(DEGREE - k)) begin
                        r_coef[k] <= data_in;
                    end
                end
            end
        end
    end

    // Load index, Horner step index, accumulator and result register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_load_idx <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            r_result   <= '0;
        end else begin
            case (r_state)
                S_LOAD_WAIT: begin
                    if (!go) begin
                        if (w_last_slot) begin
                            r_acc <= r_coef[DEGREE];
                            r_i   <= IDX_W'(DEGREE - 1);
                        end else begin
                            r_load_idx <= r_load_idx + IDX_W'(1);
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_alu_y;
                end
                S_ADD: begin
                    r_acc <= w_alu_y;
                    if (!w_i_zero) begin
                        r_i <= r_i - IDX_W'(1);
                    end
                end
                S_FINISH: begin
                    r_result   <= r_acc;
                    r_load_idx <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign load_idx    = r_load_idx;
    assign busy        = w_busy;
    assign done        = w_done;
    assign data_result = r_result;

endmodule : poly_eval_horner
`default_nettype wire

// File: tb/tb_poly_eval_horner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_poly_eval_horner
//  Description : Self-checking bench for poly_eval_horner. Three instances
//                (W8/D2, W8/D3, W16/D1) are driven with directed operand
//                sequences; a plain-arithmetic polynomial model supplies the
//                expected results, latency and busy duration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_eval_horner;

    logic        clk;
    logic        resetn;
    logic        go_v   [3];
    logic [15:0] din_v  [3];

    logic [1:0]  lidx_a;
    logic [2:0]  lidx_b;
    logic [1:0]  lidx_c;
    logic [7:0]  res_a;
    logic [7:0]  res_b;
    logic [15:0] res_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    logic [2:0]  lidx_v [3];
    logic [15:0] res_v  [3];
    logic        busy_v [3];
    logic        done_v [3];

    int          n_checks;
    int          n_fail;
    int          cyc;

    int          degs   [3] = '{2, 3, 1};
    int          widths [3] = '{8, 8, 16};
    logic [15:0] ops    [0:4];

    bit          exp_pend [3];
    logic [15:0] exp_val  [3];
    logic [15:0] hold_val [3];
    int          drop_cyc [3];
    int          busy_cnt [3];

    poly_eval_horner #(.WIDTH(8), .DEGREE(2)) u_dut_a (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go_v[0]),
        .data_in     (din_v[0][7:0]),
        .load_idx    (lidx_a),
        .busy        (busy_a),
        .done        (done_a),
        .data_result (res_a)
    );

    poly_eval_horner #(.WIDTH(8), .DEGREE(3)) u_dut_b (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go_v[1]),
        .data_in     (din_v[1][7:0]),
        .load_idx    (lidx_b),
        .busy        (busy_b),
        .done        (done_b),
        .data_result (res_b)
    );

    poly_eval_horner #(.WIDTH(16), .DEGREE(1)) u_dut_c (
        .clk         (clk),
        .resetn      (resetn),
        .go          (go_v[2]),
        .data_in     (din_v[2]),
        .load_idx    (lidx_c),
        .busy        (busy_c),
        .done        (done_c),
        .data_result (res_c)
    );

    assign lidx_v[0] = {1'b0, lidx_a};
    assign lidx_v[1] = lidx_b;
    assign lidx_v[2] = {1'b0, lidx_c};
    assign res_v[0]  = {8'h00, res_a};
    assign res_v[1]  = {8'h00, res_b};
    assign res_v[2]  = res_c;
    assign busy_v[0] = busy_a;
    assign busy_v[1] = busy_b;
    assign busy_v[2] = busy_c;
    assign done_v[0] = done_a;
    assign done_v[1] = done_b;
    assign done_v[2] = done_c;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Direct power-sum evaluation: sum of c[k]*x^k, reduced mod 2^w
    function automatic logic [15:0] model(input int w, input int deg);
        longint mask;
        longint acc;
        longint p;
        longint xv;
        mask = (longint'(1) << w) - 1;
        acc  = 0;
        p    = 1;
        xv   = longint'(ops[deg + 1]);
        for (int k = 0; k <= deg; k++) begin
            acc = (acc + longint'(ops[deg - k]) * p) & mask;
            p   = (p * xv) & mask;
        end
        return 16'(acc);
    endfunction

    // Per-cycle compare against the model expectations
    always @(negedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                exp_pend[i] = 1'b0;
                hold_val[i] = '0;
                chk("reset_done", 16'(done_v[i]), 16'd0);
                chk("reset_busy", 16'(busy_v[i]), 16'd0);
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (busy_v[i]) busy_cnt[i]++;
                chk($sformatf("result_hold[%0d]", i), res_v[i], hold_val[i]);
                if (done_v[i]) begin
                    if (!exp_pend[i]) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_done[%0d]: got done=1, expected 0 (t=%0t)", i, $time);
                    end else begin
                        chk($sformatf("latency[%0d]", i), 16'(cyc - drop_cyc[i]), 16'(2 * degs[i] + 1));
                        chk($sformatf("busy_cycles[%0d]", i), 16'(busy_cnt[i]), 16'(2 * degs[i]));
                        hold_val[i] = exp_val[i];
                        exp_pend[i] = 1'b0;
                    end
                end
            end
        end
    end

    // Enter all operands for one instance; called on a negedge in LOAD/idx 0
    task automatic load_ops(input int inst, input int hold, input bit toggle);
        int nops;
        nops = degs[inst] + 2;
        for (int k = 0; k < nops; k++) begin
            chk($sformatf("load_idx[%0d]", inst), 16'(lidx_v[inst]), 16'(k));
            din_v[inst] = ops[k];
            go_v[inst]  = 1'b1;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (h == 0) din_v[inst] = 16'hA5C3;
            end
            go_v[inst] = 1'b0;
            if (k == nops - 1) begin
                exp_val[inst]  = model(widths[inst], degs[inst]);
                exp_pend[inst] = 1'b1;
                drop_cyc[inst] = cyc;
                busy_cnt[inst] = 0;
            end else begin
                @(negedge clk);
            end
        end
        if (toggle) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                go_v[inst]  = ~go_v[inst];
                din_v[inst] = 16'($urandom);
            end
            @(negedge clk);
            go_v[inst] = 1'b0;
        end
    endtask

    task automatic run(input int inst, input int hold, input bit toggle, input logic [15:0] lit);
        chk($sformatf("model_pin[%0d]", inst), model(widths[inst], degs[inst]), lit);
        @(negedge clk);
        load_ops(inst, hold, toggle);
        for (int t = 0; t < 64 && exp_pend[inst]; t++) @(negedge clk);
        if (exp_pend[inst]) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_timeout[%0d]: got no done, expected done within 64 cycles", inst);
            exp_pend[inst] = 1'b0;
        end
        @(negedge clk);
        chk($sformatf("result_literal[%0d]", inst), res_v[inst], lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200us");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            go_v[i]  = 1'b0;
            din_v[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_load_idx[%0d]", i), 16'(lidx_v[i]), 16'd0);
            chk($sformatf("rst_busy[%0d]", i), 16'(busy_v[i]), 16'd0);
            chk($sformatf("rst_done[%0d]", i), 16'(done_v[i]), 16'd0);
            chk($sformatf("rst_result[%0d]", i), res_v[i], 16'd0);
        end
        resetn = 1'b1;

        // W8/D2: 1*4 + 2*2 + 3 = 11
        ops = '{16'd1, 16'd2, 16'd3, 16'd2, 16'd0};
        run(0, 1, 1'b0, 16'h000B);

        // W8/D3: 2*125 + 1 = 251, go held 10 cycles per operand
        ops = '{16'd2, 16'd0, 16'd0, 16'd1, 16'd5};
        run(1, 10, 1'b0, 16'h00FB);

        // W8/D3: all 0xFF -> -1+1-1+1 = 0 mod 256
        ops = '{16'hFF, 16'hFF, 16'hFF, 16'hFF, 16'hFF};
        run(1, 2, 1'b0, 16'h0000);

        // Same polynomial as the clean run, go/data chatter during evaluation
        ops = '{16'd2, 16'd0, 16'd0, 16'd1, 16'd5};
        run(1, 1, 1'b1, 16'h00FB);

        // W16/D1: 0x1234*0x10 + 1 = 0x12341 -> 0x2341
        ops = '{16'h1234, 16'h0001, 16'h0010, 16'h0000, 16'h0000};
        run(2, 3, 1'b0, 16'h2341);

        // Abort an evaluation with reset while in ADD
        ops = '{16'd3, 16'd3, 16'd3, 16'd3, 16'd3};
        @(negedge clk);
        load_ops(1, 1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 16'(busy_v[1]), 16'd1);
        #2 resetn = 1'b0;
        #1;
        chk("abort_result", res_v[1], 16'd0);
        chk("abort_busy", 16'(busy_v[1]), 16'd0);
        chk("abort_done", 16'(done_v[1]), 16'd0);
        chk("abort_load_idx", 16'(lidx_v[1]), 16'd0);
        chk("abort_result_a", res_v[0], 16'd0);
        repeat (3) @(negedge clk);
        resetn = 1'b1;

        // Fresh run after the abort: 8 + 4 + 2 + 1 = 15
        ops = '{16'd1, 16'd1, 16'd1, 16'd1, 16'd2};
        run(1, 1, 1'b0, 16'h000F);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_poly_eval_horner
`default_nettype wire
